// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time, holds the
// returned word until the decoder takes it, and redirects on branch.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic        I_branch,
  input  logic [15:0] I_branch_target,
  input  logic        I_mem_ready,
  input  logic [15:0] I_mem_data,
  input  logic        I_ready,
  output logic        O_mem_req,
  output logic [15:0] O_mem_addr,
  output logic [15:0] O_instruction,
  output logic [15:0] O_pc,
  output logic        O_valid
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    req_d   = req_q;
    valid_d = valid_q;
    // Branch wins over everything, including a word arriving this cycle.
    if (I_branch) begin
      pc_d    = I_branch_target;
      req_d   = 1'b0;
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (I_enable) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        REQ: if (I_mem_ready) begin
          instr_d = I_mem_data;
          ipc_d   = pc_q;
          pc_d    = pc_q + 16'd2;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
        HOLD: if (I_ready) begin
          valid_d = 1'b0;
          if (I_enable) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= 16'h0000;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign O_mem_req     = req_q;
  assign O_mem_addr    = addr_q;
  assign O_instruction = instr_q;
  assign O_pc          = ipc_q;
  assign O_valid       = valid_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded at reset.
REQ-002 Port I_clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port I_reset, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-004 Port I_enable, input, 1, SHALL be the stage enable from the control unit; a high level permits a new fetch to start.
REQ-005 Port I_branch, input, 1, SHALL be the redirect strobe; a high level loads the PC from I_branch_target.
REQ-006 Port I_branch_target, input, 16, SHALL be the redirect address.
REQ-007 Port I_mem_ready, input, 1, SHALL indicate that I_mem_data holds the word for the current request.
REQ-008 Port I_mem_data, input, 16, SHALL be the instruction word returned by memory.
REQ-009 Port I_ready, input, 1, SHALL indicate that the decoder accepts O_instruction this cycle.
REQ-010 Port O_mem_req, output, 1, SHALL be the registered memory request.
REQ-011 Port O_mem_addr, output, 16, SHALL be the registered fetch address.
REQ-012 Port O_instruction, output, 16, SHALL be the registered fetched word: opcode [15:12], rD [11:9], rA [7:5], rB [4:2], imm [7:0].
REQ-013 Port O_pc, output, 16, SHALL be the address O_instruction was fetched from.
REQ-014 Port O_valid, output, 1, SHALL be high while O_instruction holds an unconsumed instruction.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ and HOLD, with the internal PC as a 16-bit register.
REQ-016 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-017 In IDLE with I_enable=1 and I_branch=0, the next state SHALL be REQ, with O_mem_req=1 and O_mem_addr=PC.
REQ-018 In IDLE with I_enable=0, the block SHALL stay in IDLE with O_mem_req=0.
REQ-019 In REQ, O_mem_req and O_mem_addr SHALL stay stable until I_mem_ready=1 is sampled; I_enable=0 SHALL NOT withdraw the request.
REQ-020 When REQ samples I_mem_ready=1, the next edge SHALL set:
- O_instruction=I_mem_data
- O_pc=PC
- PC=PC+2 (mod 2^16, so 16'hFFFE wraps to 16'h0000)
- O_valid=1, O_mem_req=0
- state HOLD
REQ-021 In HOLD with I_ready=0, O_valid, O_instruction and O_pc SHALL hold.
REQ-022 In HOLD with I_ready=1 and I_enable=1, the next edge SHALL clear O_valid, enter REQ and assert O_mem_req with O_mem_addr=PC (back-to-back fetch).
REQ-023 In HOLD with I_ready=1 and I_enable=0, the next edge SHALL clear O_valid and enter IDLE.
REQ-024 I_branch=1 in any state SHALL have priority over all other inputs, and the next edge SHALL set:
- PC=I_branch_target
- O_valid=0, O_mem_req=0
- state IDLE
REQ-025 When I_branch=1 and I_mem_ready=1 occur in the same cycle, the returned word SHALL be discarded and PC SHALL NOT increment.
REQ-026 Latency SHALL be:
- I_enable sampled in IDLE at edge N -> O_mem_req high after edge N.
- I_mem_ready sampled at edge M -> O_valid high after edge M.
REQ-027 An I_branch_target with bit 0 set SHALL be loaded unmodified; alignment is the caller's responsibility.

Reset
REQ-028 Asserting I_reset SHALL immediately, without waiting for a clock edge, force:
- state IDLE, PC=RESET_PC
- O_mem_req=0, O_mem_addr=16'h0000
- O_instruction=16'h0000, O_pc=16'h0000, O_valid=0
REQ-029 Reset asserted mid-request SHALL abandon the request; an I_mem_ready seen after deassertion while in IDLE SHALL be ignored.
REQ-030 The first fetch after reset deassertion SHALL use address RESET_PC.

Verification
REQ-031 Basic fetch: reset, I_enable=1, memory ready after 3 cycles with 16'h1234 -> O_mem_addr=16'h0000, then O_valid=1, O_instruction=16'h1234, O_pc=16'h0000, next fetch address 16'h0002.
REQ-032 Stall: O_valid=1 with I_ready=0 for 5 cycles -> O_instruction and O_pc are unchanged; O_mem_req=0 throughout.
REQ-033 Back-to-back: I_ready=1 in HOLD with I_enable=1 -> O_mem_req=1 and O_mem_addr=16'h0002 on the next cycle.
REQ-034 Branch collision: I_branch=1, target 16'h0040, in the same cycle as I_mem_ready=1 -> O_valid=0, IDLE, next fetch address 16'h0040, data dropped.
REQ-035 Wrap-around: branch to 16'hFFFE, then fetch -> O_pc=16'hFFFE and next O_mem_addr=16'h0000.
REQ-036 Async reset: I_reset pulsed between clock edges during REQ -> all outputs are zero before the next edge, and the next fetch is from RESET_PC.
